// File: rtl/sa_core.sv
// sa_core: output-stationary ROWS x ROWS systolic MAC array with column-serial result drain.
// Define SA_CORE_SIGNED_EN for two's-complement int8 operands; default build is unsigned.
module sa_core #(
  parameter int ROWS = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [7:0]      ainport [ROWS],
  input  logic [7:0]      winport [ROWS],
  input  logic            inpvalid,
  input  logic            outread,
  output logic [31:0]     routport [ROWS],
  output logic [0:ROWS-1] rvalidport
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(2 * ROWS);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [DW-1:0] drain_cnt;
  logic          accept;
  logic          acc_clr;

  // {valid, data} at the array edge, after the per-row / per-column skew
  logic [8:0]  a_edge [ROWS];
  logic [8:0]  w_edge [ROWS];
  logic [8:0]  a_pe   [ROWS][ROWS];
  logic [8:0]  w_pe   [ROWS][ROWS];
  logic [31:0] acc    [ROWS][ROWS];

  assign accept  = inpvalid && (state == IDLE || state == LOAD);
  assign acc_clr = (state == OUTPUT) && outread && (col == CW'(ROWS - 1));

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign a_edge[r] = {accept, ainport[r]};
      assign w_edge[r] = {accept, winport[r]};
    end else begin : g_dly
      logic [8:0] a_sr [r];
      logic [8:0] w_sr [r];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int unsigned k = 0; k < r; k++) begin
            a_sr[k] <= '0;
            w_sr[k] <= '0;
          end
        end else begin
          a_sr[0] <= {accept, ainport[r]};
          w_sr[0] <= {accept, winport[r]};
          for (int unsigned k = 1; k < r; k++) begin
            a_sr[k] <= a_sr[k-1];
            w_sr[k] <= w_sr[k-1];
          end
        end
      end
      assign a_edge[r] = a_sr[r-1];
      assign w_edge[r] = w_sr[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < ROWS; c++) begin : g_col
      logic [8:0]  a_q, w_q, a_nx, w_nx;
      logic [31:0] acc_q;
      logic [31:0] prod_ext;

      if (c == 0) begin : g_aedge
        assign a_nx = a_edge[r];
      end else begin : g_aleft
        assign a_nx = a_pe[r][c-1];
      end
      if (r == 0) begin : g_wedge
        assign w_nx = w_edge[c];
      end else begin : g_wup
        assign w_nx = w_pe[r-1][c];
      end

`ifdef SA_CORE_SIGNED_EN
      logic signed [15:0] prod;
      assign prod     = $signed(a_q[7:0]) * $signed(w_q[7:0]);
      assign prod_ext = {{16{prod[15]}}, prod};
`else
      logic [15:0] prod;
      assign prod     = a_q[7:0] * w_q[7:0];
      assign prod_ext = {16'b0, prod};
`endif

      // operands are registered here, so the MAC fires one edge after they land
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q   <= '0;
          w_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q <= a_nx;
          w_q <= w_nx;
          if (acc_clr) begin
            acc_q <= '0;
          end else if (a_q[8] && w_q[8]) begin
            acc_q <= acc_q + prod_ext;
          end
        end
      end

      assign a_pe[r][c] = a_q;
      assign w_pe[r][c] = w_q;
      assign acc[r][c]  = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      col        <= '0;
      drain_cnt  <= '0;
      rvalidport <= '0;
      for (int unsigned r = 0; r < ROWS; r++) routport[r] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inpvalid) state <= LOAD;
        end
        LOAD: begin
          if (!inpvalid) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // last beat reaches PE(ROWS-1,ROWS-1) 2*ROWS-1 edges after it was sampled
          if (drain_cnt == DW'(2 * ROWS - 2)) begin
            state      <= OUTPUT;
            col        <= '0;
            rvalidport <= '1;
            for (int unsigned r = 0; r < ROWS; r++) routport[r] <= acc[r][0];
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (outread) begin
            if (col == CW'(ROWS - 1)) begin
              state      <= IDLE;
              col        <= '0;
              rvalidport <= '0;
              for (int unsigned r = 0; r < ROWS; r++) routport[r] <= '0;
            end else begin
              col <= col + 1'b1;
              for (int unsigned r = 0; r < ROWS; r++) routport[r] <= acc[r][col + 1'b1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_core.sv
// Self-checking bench for sa_core: batch-level reference model compared every cycle,
// plus directed literal expectations and a randomized free-running phase.
module tb_sa_core;
  localparam int R = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [7:0]      ain [R];
  logic [7:0]      win [R];
  logic            inpvalid = 1'b0;
  logic            outread = 1'b0;
  logic [31:0]     rout [R];
  logic [0:R-1]    rv;

  sa_core #(.ROWS(R)) dut (
    .clk(clk), .rstn(rstn), .ainport(ain), .winport(win),
    .inpvalid(inpvalid), .outread(outread), .routport(rout), .rvalidport(rv)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, want, want, $time);
    end
  endtask

  // Reference model: results are the plain matrix sums of the batch; timing is
  // "valid from the 2*R-th edge after the last beat until the last column is taken".
  logic [31:0] m_c [R][R];
  int          phase = 0;   // 0 collecting, 1 waiting for results, 2 presenting
  int          ecount = 0;
  int          t_last = 0;
  int          nbeats = 0;
  int          mcol = 0;
  logic        exp_v = 1'b0;

  function automatic logic [31:0] mprod(input logic [7:0] a, input logic [7:0] w);
    int x, y;
`ifdef SA_CORE_SIGNED_EN
    x = int'($signed(a));
    y = int'($signed(w));
`else
    x = int'(a);
    y = int'(w);
`endif
    return 32'(x * y);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < R; c++) m_c[r][c] = '0;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase = 0; nbeats = 0; mcol = 0; exp_v = 1'b0;
      model_clear();
    end else begin
      ecount++;
      case (phase)
        0: begin
          if (inpvalid) begin
            for (int r = 0; r < R; r++)
              for (int c = 0; c < R; c++) m_c[r][c] = m_c[r][c] + mprod(ain[r], win[c]);
            nbeats++;
            t_last = ecount;
          end else if (nbeats > 0) begin
            phase = 1;
          end
        end
        1: begin
          if (ecount == t_last + 2 * R) begin
            phase = 2; exp_v = 1'b1; mcol = 0;
          end
        end
        default: begin
          if (outread) begin
            if (mcol == R - 1) begin
              model_clear();
              nbeats = 0; phase = 0; exp_v = 1'b0; mcol = 0;
            end else begin
              mcol++;
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("rvalidport", 32'(rv), exp_v ? 32'((64'd1 << R) - 1) : 32'd0);
    for (int r = 0; r < R; r++)
      check($sformatf("routport[%0d]", r), rout[r], exp_v ? m_c[r][mcol] : 32'd0);
  end

  logic [31:0] got [R][R];  // got[col][row]

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] w);
    for (int i = 0; i < R; i++) begin
      ain[i] = a;
      win[i] = w;
    end
  endtask

  task automatic drain(input bit stall, input bit ghost, input logic [31:0] pin);
    int n = 0;
    while (rv[0] !== 1'b1 && n < 4 * R + 8) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(rv[0]), 32'd1);
    if (rv[0] !== 1'b1) return;
    check("model_pin", m_c[R-1][R-1], pin);
    for (int c = 0; c < R; c++) begin
      if (stall && c == 3) begin
        outread = 1'b0;
        repeat (5) tick();
      end
      for (int r = 0; r < R; r++) got[c][r] = rout[r];
      outread = 1'b1;
      if (ghost && c == R - 1) begin
        inpvalid = 1'b1;
        set_ops(8'd5, 8'd5);
      end
      tick();
      outread = 1'b0;
      inpvalid = 1'b0;
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] want);
    for (int c = 0; c < R; c++)
      for (int r = 0; r < R; r++) check($sformatf("%s[c%0d r%0d]", name, c, r), got[c][r], want);
  endtask

  initial begin
    int n;
    set_ops(8'd0, 8'd0);
    repeat (3) tick();
    check("reset_rv", 32'(rv), 32'd0);
    check("reset_rout", rout[0], 32'd0);
    rstn = 1'b1;
    tick();

    // single beat, latency and broadcast value
    set_ops(8'd1, 8'd2);
    inpvalid = 1'b1;
    tick();
    inpvalid = 1'b0;
    n = 0;
    while (rv[0] !== 1'b1 && n < 4 * R) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(2 * R));
    drain(1'b0, 1'b0, 32'd2);
    check_all("one_beat", 32'd2);
    repeat (3) tick();

    // 16-beat batch with wrapping operand sequences; ghost beat on final accept
    for (int i = 0; i < 16; i++) begin
      set_ops(8'((1 + i) % 16), 8'((2 + i) % 9));
      inpvalid = 1'b1;
      tick();
    end
    inpvalid = 1'b0;
    drain(1'b0, 1'b1, 32'd532);
    check_all("batch16", 32'd532);
    repeat (2) tick();

    // distinct lanes with a mid-output stall
    for (int i = 0; i < R; i++) begin
      ain[i] = 8'(i + 1);
      win[i] = 8'(i + 1);
    end
    inpvalid = 1'b1;
    repeat (3) tick();
    inpvalid = 1'b0;
    drain(1'b1, 1'b0, 32'(3 * R * R));
    for (int c = 0; c < R; c++)
      for (int r = 0; r < R; r++)
        check($sformatf("lanes[c%0d r%0d]", c, r), got[c][r], 32'(3 * (r + 1) * (c + 1)));
    repeat (2) tick();

    // reset during DRAIN, then a clean one-beat batch
    set_ops(8'd77, 8'd99);
    inpvalid = 1'b1;
    repeat (2) tick();
    inpvalid = 1'b0;
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    check("rst_drain_rv", 32'(rv), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    set_ops(8'd1, 8'd1);
    inpvalid = 1'b1;
    tick();
    inpvalid = 1'b0;
    drain(1'b0, 1'b0, 32'd1);
    check_all("after_rst", 32'd1);

    // reset mid-output clears presented results at once
    set_ops(8'd9, 8'd9);
    inpvalid = 1'b1;
    tick();
    inpvalid = 1'b0;
    n = 0;
    while (rv[0] !== 1'b1 && n < 4 * R) begin
      tick();
      n++;
    end
    check("mid_out_valid", 32'(rv[0]), 32'd1);
    outread = 1'b1;
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    check("rst_out_rv", 32'(rv), 32'd0);
    check("rst_out_rout", rout[R-1], 32'd0);
    outread = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // accumulator wrap: 66100 * 65025 mod 2^32
    set_ops(8'd255, 8'd255);
    inpvalid = 1'b1;
    repeat (66100) tick();
    inpvalid = 1'b0;
    drain(1'b0, 1'b0, 32'd3185204);
    check_all("wrap", 32'd3185204);

    // randomized free-running traffic, occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 599) != 0);
      if (inpvalid) inpvalid = ($urandom_range(0, 9) != 0);
      else          inpvalid = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < R; k++) begin
        ain[k] = 8'($urandom);
        win[k] = 8'($urandom);
      end
      outread = ($urandom_range(0, 9) < 7);
      tick();
    end
    rstn = 1'b1;
    inpvalid = 1'b0;
    outread = 1'b1;
    repeat (4 * R + 16) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
